// File: rtl/wam_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : wam_pkg                                                   |
// | Purpose  : Shared types, widths and defaults for the whack-a-mole    |
// |            round controller and its prescaler.                       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package wam_pkg;

  // Game phase encoding, also driven straight out on the state port
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    PLAY  = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam int SCORE_W = 8;
  localparam int TIME_W  = 7;
  localparam int HRDN_W  = 4;
  localparam int MISS_W  = 3;
  localparam int HIT_W   = 8;

  localparam int unsigned DEF_TICK_DIV  = 50_000_000;
  localparam int unsigned DEF_GAME_TIME = 60;

  // Difficulty step for a given score, capped at the top code
  function automatic logic [HRDN_W-1:0] calc_hrdn(input logic [SCORE_W-1:0] score_in,
                                                  input int unsigned       pts);
    int unsigned lvl;
    lvl = 32'(score_in) / pts;
    if (lvl > 32'd15) return '1;
    return lvl[HRDN_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/wam_tick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : wam_tick                                                  |
// | Purpose  : Enable-gated prescaler producing a one-cycle strobe every |
// |            DIV enabled cycles; sclr restarts the count.              |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module wam_tick #(
  parameter int unsigned DIV = 8
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  input  logic sclr,
  output logic tick
);

  localparam int unsigned     c_cw   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(DIV - 1);

  logic [c_cw-1:0] r_cnt;

  // Strobe on the last count of each period, only while counting
  assign tick = en & (r_cnt == c_last);

  // Period counter: wraps on the strobe, restarts on sclr
  always_ff @(posedge clk or posedge clr) begin
    if (clr)       r_cnt <= '0;
    else if (sclr) r_cnt <= '0;
    else if (en)   r_cnt <= tick ? '0 : r_cnt + c_cw'(1);
  end

endmodule
`default_nettype wire

// File: rtl/wam_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : wam_ctrl                                                  |
// | Purpose  : Whack-a-mole round controller: idle/countdown/play/over   |
// |            sequencing, hit qualification, score, misses, difficulty. |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module wam_ctrl
  import wam_pkg::*;
#(
  parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
  parameter int unsigned GAME_TIME = DEF_GAME_TIME,
  parameter int unsigned CNT_DOWN  = 3,
  parameter int unsigned LEVEL_PTS = 8,
  parameter int unsigned MAX_MISS  = 5
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [HIT_W-1:0]   hit,
  input  logic [HIT_W-1:0]   holes,
  output logic               gen_clr,
  output logic [HRDN_W-1:0]  hrdn,
  output logic [HIT_W-1:0]   hit_q,
  output logic [1:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic [MISS_W-1:0]  misses,
  output logic [TIME_W-1:0]  time_left,
  output logic               tick
);

  localparam int                c_cnt_w     = $clog2(HIT_W + 1);
  localparam logic [TIME_W-1:0] c_game_time = TIME_W'(GAME_TIME);
  localparam logic [TIME_W-1:0] c_cnt_down  = TIME_W'(CNT_DOWN);
  localparam logic [TIME_W-1:0] c_time_one  = TIME_W'(1);
  localparam logic [c_cnt_w:0]  c_miss_lim  = (c_cnt_w + 1)'(MAX_MISS);
  localparam logic [MISS_W-1:0] c_miss_max  = MISS_W'(MAX_MISS);

  state_t               r_state, w_next_state;
  logic                 r_start_d, r_start_re;
  logic [HIT_W-1:0]     r_hit_d, r_hit_re;
  logic [SCORE_W-1:0]   r_score, w_score_nx;
  logic [MISS_W-1:0]    r_misses, w_misses_nx;
  logic [TIME_W-1:0]    r_time, w_time_nx;
  logic [HRDN_W-1:0]    r_hrdn;
  logic                 w_round_clr;
  logic                 w_tick;
  logic                 w_tick_en;
  logic                 w_tick_sclr;

  logic [HIT_W-1:0]     w_valid, w_miss;
  logic [c_cnt_w-1:0]   w_n_valid, w_n_miss;
  logic [SCORE_W:0]     w_score_sum;
  logic [SCORE_W-1:0]   w_score_sat;
  logic [c_cnt_w:0]     w_miss_sum;
  logic [MISS_W-1:0]    w_miss_sat;
  logic                 w_miss_end;

  // Second prescaler runs only during countdown and play; every phase change restarts it
  assign w_tick_en   = (r_state == READY) || (r_state == PLAY);
  assign w_tick_sclr = (w_next_state != r_state);

  wam_tick #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .clr  (clr),
    .en   (w_tick_en),
    .sclr (w_tick_sclr),
    .tick (w_tick)
  );

  // Level history keeps tracking through reset so a held button never looks like a new press
  always_ff @(posedge clk) begin
    r_start_d <= start;
    r_hit_d   <= hit;
  end

  // Hit classification and per-cycle popcounts with saturating updates
  always_comb begin
    w_valid   = r_hit_re & holes;
    w_miss    = r_hit_re & ~holes;
    w_n_valid = '0;
    w_n_miss  = '0;
    for (int i = 0; i < HIT_W; i++) begin
      w_n_valid = w_n_valid + c_cnt_w'(w_valid[i]);
      w_n_miss  = w_n_miss  + c_cnt_w'(w_miss[i]);
    end
    w_score_sum = {1'b0, r_score} + (SCORE_W + 1)'(w_n_valid);
    w_score_sat = w_score_sum[SCORE_W] ? '1 : w_score_sum[SCORE_W-1:0];
    w_miss_sum  = (c_cnt_w + 1)'(r_misses) + (c_cnt_w + 1)'(w_n_miss);
    w_miss_end  = (w_miss_sum >= c_miss_lim);
    w_miss_sat  = w_miss_end ? c_miss_max : w_miss_sum[MISS_W-1:0];
  end

  // Phase register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next phase plus next score/misses/time; a round start clears the round counters
  always_comb begin
    w_next_state = r_state;
    w_score_nx   = r_score;
    w_misses_nx  = r_misses;
    w_time_nx    = r_time;
    w_round_clr  = 1'b0;
    case (r_state)
      IDLE, OVER: begin
        if (r_start_re) begin
          w_next_state = READY;
          w_time_nx    = c_cnt_down;
          w_score_nx   = '0;
          w_misses_nx  = '0;
          w_round_clr  = 1'b1;
        end
      end
      READY: begin
        if (w_tick) begin
          if (r_time == c_time_one) begin
            w_next_state = PLAY;
            w_time_nx    = c_game_time;
          end else begin
            w_time_nx    = r_time - c_time_one;
          end
        end
      end
      PLAY: begin
        w_score_nx  = w_score_sat;
        w_misses_nx = w_miss_sat;
        if (w_tick) w_time_nx = r_time - c_time_one;
        if ((w_tick && (r_time == c_time_one)) || w_miss_end) w_next_state = OVER;
      end
      default: ;
    endcase
  end

  // Round counters and registered edge strobes
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_score    <= '0;
      r_misses   <= '0;
      r_time     <= c_game_time;
      r_start_re <= 1'b0;
      r_hit_re   <= '0;
    end else begin
      r_score    <= w_score_nx;
      r_misses   <= w_misses_nx;
      r_time     <= w_time_nx;
      r_start_re <= start & ~r_start_d;
      r_hit_re   <= hit & ~r_hit_d;
    end
  end

  // Difficulty follows the registered score one cycle later
  always_ff @(posedge clk or posedge clr) begin
    if (clr)              r_hrdn <= '0;
    else if (w_round_clr) r_hrdn <= '0;
    else                  r_hrdn <= calc_hrdn(r_score, LEVEL_PTS);
  end

  assign gen_clr   = (r_state != PLAY);
  assign hit_q     = (r_state == PLAY) ? w_valid : '0;
  assign hrdn      = r_hrdn;
  assign state     = r_state;
  assign score     = r_score;
  assign misses    = r_misses;
  assign time_left = r_time;
  assign tick      = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_wam_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_wam_ctrl                                               |
// | Purpose  : Scoreboard bench for wam_ctrl with directed game rounds.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_wam_ctrl;

  logic       clk = 1'b0;
  logic       clr, start, start2;
  logic [7:0] hit, holes, hit2, holes2;

  logic       gen_clr, tick;
  logic [3:0] hrdn;
  logic [7:0] hit_q, score;
  logic [1:0] state;
  logic [2:0] misses;
  logic [6:0] time_left;

  logic       s_gen_clr, s_tick;
  logic [3:0] s_hrdn;
  logic [7:0] s_hit_q, s_score;
  logic [1:0] s_state;
  logic [2:0] s_misses;
  logic [6:0] s_time_left;

  always #5 clk = ~clk;

  wam_ctrl #(.TICK_DIV(8), .GAME_TIME(4), .CNT_DOWN(3), .LEVEL_PTS(2), .MAX_MISS(5)) dut (
    .clk(clk), .clr(clr), .start(start), .hit(hit), .holes(holes),
    .gen_clr(gen_clr), .hrdn(hrdn), .hit_q(hit_q), .state(state), .score(score),
    .misses(misses), .time_left(time_left), .tick(tick));

  // Long game so the score can be driven into saturation
  wam_ctrl #(.TICK_DIV(8), .GAME_TIME(100), .CNT_DOWN(3), .LEVEL_PTS(2), .MAX_MISS(5)) u_sat (
    .clk(clk), .clr(clr), .start(start2), .hit(hit2), .holes(holes2),
    .gen_clr(s_gen_clr), .hrdn(s_hrdn), .hit_q(s_hit_q), .state(s_state), .score(s_score),
    .misses(s_misses), .time_left(s_time_left), .tick(s_tick));

  typedef struct { int hq; int score; int hrdn; } hq_t;
  typedef struct { int st; int tl; int score; int misses; int gc; int hrdn; } st_t;
  typedef struct { int sel; int exp; int step; } pr_t;

  hq_t q_hq[$];
  st_t q_st[$];
  pr_t q_pr[$];
  int  n_chk = 0;
  int  n_fail = 0;
  int  step = 0;

  function automatic int get_sig(input int sel);
    case (sel)
      0:  return int'(state);
      1:  return int'(score);
      2:  return int'(misses);
      3:  return int'(hrdn);
      4:  return int'(time_left);
      5:  return int'(gen_clr);
      6:  return int'(hit_q);
      7:  return int'(tick);
      8:  return int'(s_score);
      9:  return int'(s_hrdn);
      10: return int'(s_state);
      11: return q_hq.size();
      12: return q_st.size();
      default: return -1;
    endcase
  endfunction

  function automatic string sig_name(input int sel);
    case (sel)
      0: return "state";      1: return "score";   2: return "misses";
      3: return "hrdn";       4: return "time_left"; 5: return "gen_clr";
      6: return "hit_q";      7: return "tick";    8: return "sat_score";
      9: return "sat_hrdn";   10: return "sat_state"; 11: return "hq_queue_left";
      12: return "st_queue_left";
      default: return "unknown";
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic probe(input int sel, input int exp);
    pr_t p;
    p.sel = sel; p.exp = exp; p.step = step;
    q_pr.push_back(p);
  endtask

  task automatic exp_st(input int st, input int tl, input int sc, input int mi, input int gc, input int hr);
    st_t e;
    e.st = st; e.tl = tl; e.score = sc; e.misses = mi; e.gc = gc; e.hrdn = hr;
    q_st.push_back(e);
  endtask

  task automatic exp_hq(input int hq, input int sc, input int hr);
    hq_t e;
    e.hq = hq; e.score = sc; e.hrdn = hr;
    q_hq.push_back(e);
  endtask

  task automatic wait_state(input int s, input int budget);
    for (int n = 0; n < budget && int'(state) != s; n++) @(negedge clk);
    @(posedge clk); #1;
    probe(0, s);
  endtask

  // Monitor: compares every strobe, phase change and queued probe at the falling edge
  logic [1:0] prev_state = 2'd0;
  int sc_pend = 0, hr_pend = 0, sc_exp = 0, hr_exp = 0, hr_next = 0;
  always @(negedge clk) begin
    hq_t h;
    st_t s;
    pr_t p;
    if (hr_pend != 0) begin chk("hrdn_after_score", int'(hrdn), hr_exp); hr_pend = 0; end
    if (sc_pend != 0) begin
      chk("score_after_hit", int'(score), sc_exp);
      sc_pend = 0; hr_pend = 1; hr_exp = hr_next;
    end
    if (hit_q != 8'h00) begin
      if (q_hq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL hit_q_unexpected: got %0h, expected no strobe", hit_q);
      end else begin
        h = q_hq.pop_front();
        chk("hit_q", int'(hit_q), h.hq);
        sc_pend = 1; sc_exp = h.score; hr_next = h.hrdn;
      end
    end
    if (state != prev_state) begin
      if (q_st.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL state_unexpected: got %0d, expected %0d", state, prev_state);
      end else begin
        s = q_st.pop_front();
        chk("entry_state", int'(state), s.st);
        chk("entry_time_left", int'(time_left), s.tl);
        chk("entry_score", int'(score), s.score);
        chk("entry_misses", int'(misses), s.misses);
        chk("entry_gen_clr", int'(gen_clr), s.gc);
        chk("entry_hrdn", int'(hrdn), s.hrdn);
      end
    end
    prev_state = state;
    while (q_pr.size() > 0) begin
      p = q_pr.pop_front();
      chk($sformatf("%s_step%0d", sig_name(p.sel), p.step), get_sig(p.sel), p.exp);
    end
  end

  initial begin
    clr = 1'b1; start = 1'b0; start2 = 1'b0;
    hit = '0; holes = '0; hit2 = '0; holes2 = 8'hFF;

    // Reset values
    step = 1;
    repeat (2) @(posedge clk); #1;
    probe(0, 0); probe(1, 0); probe(2, 0); probe(3, 0);
    probe(4, 4); probe(5, 1); probe(6, 0); probe(7, 0);
    @(posedge clk); #1;
    clr = 1'b0;

    // Start -> countdown -> play
    step = 2;
    @(posedge clk); #1;
    exp_st(1, 3, 0, 0, 1, 0);
    exp_st(2, 4, 0, 0, 0, 0);
    start = 1'b1;
    wait_state(1, 10);
    repeat (6) @(posedge clk); #1;
    probe(7, 1); probe(4, 3);
    @(posedge clk); #1;
    probe(7, 0); probe(4, 2);
    start = 1'b0;
    wait_state(2, 60);

    // Two live moles hit together
    step = 3;
    exp_hq(8'h05, 2, 1);
    holes = 8'h05; hit = 8'h05;
    repeat (3) @(posedge clk); #1;
    hit = '0; holes = '0;
    probe(2, 0);

    // Five misses end the round
    step = 4;
    exp_st(3, 3, 2, 5, 1, 1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1; hit = 8'h08;
      @(posedge clk); #1; hit = '0;
    end
    wait_state(3, 20);
    holes = 8'hFF; hit = 8'hFF;
    repeat (3) @(posedge clk); #1;
    probe(1, 2); probe(2, 5); probe(5, 1); probe(4, 3);
    hit = '0; holes = '0;

    // Restart from OVER, mixed hit/miss, then run out the clock
    step = 5;
    exp_st(1, 3, 0, 0, 1, 0);
    exp_st(2, 4, 0, 0, 0, 0);
    start = 1'b1;
    wait_state(1, 10);
    start = 1'b0;
    wait_state(2, 40);
    exp_hq(8'h07, 3, 1);
    exp_st(3, 0, 3, 1, 1, 1);
    holes = 8'h07; hit = 8'h0F;
    repeat (2) @(posedge clk); #1;
    hit = '0; holes = '0;
    wait_state(3, 60);
    repeat (2) @(posedge clk); #1;
    probe(3, 1); probe(1, 3); probe(4, 0); probe(2, 1);

    // Saturation on the long-game instance
    step = 6;
    @(posedge clk); #1;
    start2 = 1'b1;
    for (int n = 0; n < 60 && s_state != 2'd2; n++) @(negedge clk);
    @(posedge clk); #1;
    probe(10, 2);
    start2 = 1'b0;
    for (int k = 0; k < 31; k++) begin
      @(posedge clk); #1; hit2 = 8'hFF;
      @(posedge clk); #1; hit2 = '0;
    end
    repeat (3) @(posedge clk); #1;
    probe(8, 248); probe(9, 15);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1; hit2 = 8'hFF;
      @(posedge clk); #1; hit2 = '0;
    end
    repeat (3) @(posedge clk); #1;
    probe(8, 255); probe(9, 15); probe(10, 2);

    // Asynchronous clear in the middle of play with buttons held
    step = 7;
    exp_st(1, 3, 0, 0, 1, 0);
    exp_st(2, 4, 0, 0, 0, 0);
    start = 1'b1;
    wait_state(1, 10);
    start = 1'b0;
    wait_state(2, 40);
    exp_hq(8'hFF, 8, 4);
    holes = 8'hFF; hit = 8'hFF;
    repeat (2) @(posedge clk); #1;
    hit = '0;
    repeat (3) @(posedge clk); #1;
    exp_st(0, 4, 0, 0, 1, 0);
    hit = 8'hFF; start = 1'b1; clr = 1'b1;
    #1;
    probe(0, 0); probe(1, 0); probe(2, 0); probe(3, 0);
    probe(4, 4); probe(5, 1); probe(6, 0); probe(7, 0);
    repeat (3) @(posedge clk); #1;
    clr = 1'b0;
    repeat (20) @(posedge clk); #1;
    probe(0, 0); probe(1, 0); probe(6, 0); probe(5, 1);
    start = 1'b0; hit = '0; holes = '0;
    @(posedge clk); #1;
    probe(11, 0); probe(12, 0);
    repeat (3) @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wam_ctrl.md
Name: wam_ctrl

Overview:
- Game-round controller for the whack-a-mole datapath: sequences the mole generator through idle, countdown, play and game-over phases.
- Holds the mole generator in clear outside play, and qualifies player hits against live moles.
- Keeps score and misses, and ramps the 4-bit difficulty code (hrdn) as the score grows.
- Sits between the debounced button/hit inputs and the mole generator; its score and time outputs feed the display logic.

Parameters:
- TICK_DIV, 50_000_000: clk cycles per one-second tick (benches use 8).
- GAME_TIME, 60: play duration in seconds; 7-bit, range 1..127.
- CNT_DOWN, 3: countdown seconds before play; 2-bit, range 1..3.
- LEVEL_PTS, 8: score points per difficulty step.
- MAX_MISS, 5: number of misses that ends the game.

Ports:
- clk: in, 1. System clock.
- clr: in, 1. Reset; asynchronous, active-high.
- start: in, 1. Debounced start button, level.
- hit: in, 8. Debounced per-hole hit buttons, level.
- holes: in, 8. Live-mole map from the mole generator.
- gen_clr: out, 1. Held-clear for the mole generator.
- hrdn: out, 4. Difficulty code to the mole generator.
- hit_q: out, 8. One-cycle qualified hit strobes to the generator.
- state: out, 2. Game state encoding.
- score: out, 8. Valid hits, saturating.
- misses: out, 3. Hits on empty holes.
- time_left: out, 7. Seconds remaining (countdown or play).
- tick: out, 1. One-cycle second strobe, for display blink.

Behaviour:
- Reset values (clr=1):
  - state=IDLE, score=0, misses=0, hrdn=0.
  - time_left=GAME_TIME, gen_clr=1, hit_q=0, tick=0.
  - Prescaler=0; edge registers load the current start/hit levels, so a held button does not fire after reset.
- State encoding: IDLE=0, READY=1, PLAY=2, OVER=3.
- Edge detect: start_re and hit_re[i] are rising edges, registered; they act one cycle after the input rises.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in READY and PLAY; tick=1 on the wrap cycle.
  - Cleared on every state entry, so the first tick comes TICK_DIV cycles after entry.
- IDLE:
  - gen_clr=1.
  - start_re -> READY: time_left=CNT_DOWN; score, misses and hrdn cleared.
- READY:
  - gen_clr=1; hits are ignored.
  - Each tick decrements time_left.
  - A tick with time_left==1 -> PLAY: time_left=GAME_TIME, gen_clr=0 from the next cycle.
- PLAY: gen_clr=0.
  - Per hole i:
    - hit_re[i] & holes[i] -> valid hit; hit_q[i]=1 for one cycle.
    - hit_re[i] & ~holes[i] -> miss.
  - Multiple holes in the same cycle:
    - score += popcount(valid), saturating at 255.
    - misses += popcount(miss), saturating at MAX_MISS.
  - hrdn = min(15, score / LEVEL_PTS), recomputed registered from the new score (one cycle after the score update).
  - Each tick decrements time_left.
  - -> OVER when a tick occurs with time_left==1 (time_left becomes 0), or when the updated misses value is >= MAX_MISS.
  - If both end conditions occur in the same cycle: go to OVER; that cycle's hits still count.
- OVER:
  - gen_clr=1; score, misses, time_left and hrdn frozen; hits ignored.
  - start_re -> READY, with the same clearing as from IDLE.
- start_re in READY or PLAY is ignored (no restart mid-round).
- clr in any state returns to the reset values on the same edge; the prescaler restarts.
- hit_q is 0 in every state other than PLAY.

Decomposition:
- Shared package wam_pkg holds:
  - State localparams IDLE/READY/PLAY/OVER.
  - Width constants: SCORE_W=8, TIME_W=7, HRDN_W=4.
  - Default TICK_DIV and GAME_TIME.
- One sub-module, wam_tick: a parameterized prescaler with a synchronous clear input and a tick strobe output, reusable by the display blink logic.
- Edge detect and popcount stay inline.

Test Plan (TICK_DIV=8, GAME_TIME=4, CNT_DOWN=3, LEVEL_PTS=2, MAX_MISS=5):
- Reset then start pulse -> state goes 0->1 with time_left=3.
  - After 3 ticks (24 cycles): state=2, time_left=4, gen_clr falls.
- PLAY, holes=8'h05, hit=8'h05 rising together -> hit_q=8'h05 for 1 cycle, score 0->2.
  - One cycle later hrdn=1; misses stays 0.
- PLAY, holes=8'h00, hit[3] pulsed 5 times -> misses reaches 5, then state=3 on the fifth miss.
  - gen_clr=1; score is unchanged.
- No activity in PLAY -> after 4 ticks: time_left=0, state=3; score and hrdn are held.
- Score forced near saturation -> score stops at 255 and hrdn stops at 15, even with further hits.
- clr asserted mid-PLAY, with hit held high across the deassertion -> all outputs return to their reset values immediately.
  - No hit_q and no score change after clr falls.
  - Start held high across clr does not enter READY.
